// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder sequencer driving an external 1-bit full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic carry_q;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(WIDTH - 1);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next-state: start only honoured in IDLE, DONE always lasts one cycle
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start) state_nxt = RUN;
        else if (state == RUN && last) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end
    // outputs decoded from state; adder inputs are quiet outside RUN
    always_comb begin
        busy   = state == RUN || state == DONE;
        done   = state == DONE;
        fa_a   = state == RUN ? a_sh[0] : 1'b0;
        fa_b   = state == RUN ? b_sh[0] : 1'b0;
        fa_cin = state == RUN ? carry_q : 1'b0;
    end
    // datapath: load on accepted start, one bit per RUN edge, publish result on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh    <= a;
            b_sh    <= b;
            s_sh    <= '0;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            s_sh    <= {fa_s, s_sh[WIDTH-1:1]};
            carry_q <= fa_cout;
            if (!last) cnt <= cnt + 1'b1;
            if (last) begin
                sum  <= {fa_s, s_sh[WIDTH-1:1]};
                cout <= fa_cout;
                ovf  <= (fa_a == fa_b) && (fa_s != fa_a);
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: table, directed and random checks of the serial adder sequencer at WIDTH 8 and 4
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start8, cin8, start4, cin4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8, busy8, done8, cout8, ovf8;
    logic fa_a4, fa_b4, fa_cin4, fa_s4, fa_cout4, busy4, done4, cout4, ovf4;

    assign fa_s8    = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8 = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 | fa_b8));
    assign fa_s4    = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_cin4 & (fa_a4 | fa_b4));

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_cout(fa_cout8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_s(fa_s4), .fa_cout(fa_cout4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_sum8;

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // arithmetic reference: modular sum, carry out and signed-range overflow
    function automatic void model(input int w, input int x, input int y, input int c,
                                  output int s, output int co, output int ov);
        int tot, h, sx, sy, st;
        tot = x + y + c;
        s   = tot % (1 << w);
        co  = (tot >> w) & 1;
        h   = 1 << (w - 1);
        sx  = x >= h ? x - 2 * h : x;
        sy  = y >= h ? y - 2 * h : y;
        st  = sx + sy + c;
        ov  = (st > h - 1 || st < -h) ? 1 : 0;
    endfunction

    // carry entering bit i of x+y+c
    function automatic int carry_in(input int x, input int y, input int c, input int i);
        int m;
        m = (1 << i) - 1;
        return ((x & m) + (y & m) + c) >> i;
    endfunction

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input string tag,
                       output logic [7:0] rs, output logic rc, output logic ro);
        int done_at, busy_n, done_n, bad_fa, bad_hold;
        done_at = 0; busy_n = 0; done_n = 0; bad_fa = 0; bad_hold = 0;
        rs = 'x; rc = 1'bx; ro = 1'bx;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at == 0) done_at = c;
                rs = sum8; rc = cout8; ro = ovf8;
            end
            if (busy8 && !done8) begin
                if (c > 8) bad_fa++;
                else if ({fa_a8, fa_b8, fa_cin8} !== {ta[c-1], tb[c-1], 1'(carry_in(int'(ta), int'(tb), int'(tc), c - 1))})
                    bad_fa++;
                if (sum8 !== prev_sum8) bad_hold++;
            end
            if (!busy8) break;
            @(posedge clk);
            #1;
        end
        chk({tag, " done_cycle"}, done_at, 9);
        chk({tag, " busy_cycles"}, busy_n, 9);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " fa_drive_errs"}, bad_fa, 0);
        chk({tag, " sum_hold_errs"}, bad_hold, 0);
        chk({tag, " fa_idle"}, {fa_a8, fa_b8, fa_cin8}, 0);
    endtask

    initial begin
        logic [7:0] rs;
        logic rc, ro;
        int es, ec, eo, first_done, second, pb, glitches;
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vt[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vt[6] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out8", {busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_cin8}, 0);
        chk("reset out4", {busy4, done4, sum4, cout4, ovf4, fa_a4, fa_b4, fa_cin4}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle after reset", {busy8, done8, fa_a8, fa_b8, fa_cin8}, 0);
        prev_sum8 = 8'h00;

        foreach (vt[i]) begin
            op8(vt[i].a, vt[i].b, vt[i].c, $sformatf("vec%0d", i), rs, rc, ro);
            chk($sformatf("vec%0d result", i), {rs, rc, ro}, {vt[i].s, vt[i].co, vt[i].ov});
            prev_sum8 = vt[i].s;
        end

        // start held high: operands change mid-RUN, next accept only from IDLE
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        first_done = 0; second = 0; pb = 1; rs = 'x;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin a8 = 8'h10; b8 = 8'h10; end
            if (done8 && first_done == 0) begin first_done = c; rs = sum8; end
            if (busy8 && pb == 0) begin second = c; break; end
            pb = int'(busy8);
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        chk("hold first done_cycle", first_done, 9);
        chk("hold first sum", rs, 8'h02);
        chk("hold start spacing", second - 1, 10);
        rs = 'x;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin rs = sum8; break; end
            @(posedge clk);
            #1;
        end
        chk("hold second sum", rs, 8'h20);
        @(posedge clk);
        #1;
        chk("hold back to idle", busy8, 0);
        prev_sum8 = 8'h20;

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outs", {busy8, done8, sum8, cout8, ovf8, fa_a8, fa_b8, fa_cin8}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        glitches = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) glitches++;
        end
        chk("no activity after reset", glitches, 0);
        prev_sum8 = 8'h00;
        op8(8'h80, 8'h80, 1'b0, "post_reset", rs, rc, ro);
        chk("post_reset result", {rs, rc, ro}, {8'h00, 1'b1, 1'b1});
        prev_sum8 = 8'h00;

        for (int i = 0; i < 25; i++) begin
            logic [7:0] x, y;
            logic c;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            model(8, int'(x), int'(y), int'(c), es, ec, eo);
            op8(x, y, c, $sformatf("rnd%0d", i), rs, rc, ro);
            chk($sformatf("rnd%0d result a=%0h b=%0h c=%0d", i, x, y, c), {rs, rc, ro}, {8'(es), 1'(ec), 1'(eo)});
            prev_sum8 = 8'(es);
        end

        // narrow instance: fixed 7+1 then random operands
        for (int i = 0; i < 11; i++) begin
            logic [3:0] x, y, r;
            logic c, r_c, r_o;
            int done_at;
            x = i == 0 ? 4'h7 : 4'($urandom_range(0, 15));
            y = i == 0 ? 4'h1 : 4'($urandom_range(0, 15));
            c = i == 0 ? 1'b0 : 1'($urandom_range(0, 1));
            model(4, int'(x), int'(y), int'(c), es, ec, eo);
            done_at = 0; r = 'x; r_c = 1'bx; r_o = 1'bx;
            @(negedge clk);
            a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
            @(posedge clk);
            #1 start4 = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                if (done4 && done_at == 0) begin done_at = k; r = sum4; r_c = cout4; r_o = ovf4; end
                if (!busy4) break;
                @(posedge clk);
                #1;
            end
            chk($sformatf("w4 op%0d done_cycle", i), done_at, 5);
            chk($sformatf("w4 op%0d result a=%0h b=%0h c=%0d", i, x, y, c), {r, r_c, r_o}, {4'(es), 1'(ec), 1'(eo)});
            if (i == 0) chk("w4 7+1 fixed", {r, r_o}, {4'h8, 1'b1});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
